// File: rtl/sg13g2_io_gpio_pkg.sv
// Shared register-map constants for the sg13g2 GPIO bank.
// Optional input debounce is controlled by IO_GPIO_DEBOUNCE_EN (see sg13g2_io_gpio_in).
package sg13g2_io_gpio_pkg;

    localparam int GPIO_ADDR_W = 3;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DOUT = 3'd0;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DOE  = 3'd1;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DIN  = 3'd2;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_STAT = 3'd3;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IEN  = 3'd4;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_EDGE = 3'd5;

endpackage

// File: rtl/sg13g2_io_gpio_in.sv
// One pad input: 2-flop synchroniser, optional debounce (IO_GPIO_DEBOUNCE_EN), edge match.
// filt_o lags p2c_i by 2 edges (plus 2**DEB_W with debounce); evt_o is combinational.
module sg13g2_io_gpio_in #(
    parameter int unsigned DEB_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic p2c_i,
    input  logic ien_i,
    input  logic edge_sel_i,
    output logic filt_o,
    output logic evt_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;
    logic filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= p2c_i;
            s2_q   <= s1_q;
            prev_q <= filt;
        end
    end

`ifdef IO_GPIO_DEBOUNCE_EN
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic             filt_q;
    logic             filt_d;

    // The synchronised level must disagree with filt for 2**DEB_W consecutive edges.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (s2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == {DEB_W{1'b1}}) begin
            filt_d = s2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = s2_q;
    if (DEB_W == 0) begin : g_deb_w_unused
    end
`endif

    assign filt_o = filt;
    assign evt_o  = ien_i & (filt != prev_q) & (filt == edge_sel_i);

endmodule

// File: rtl/sg13g2_io_gpio_bank.sv
// GPIO bank: register file, W1C edge status and irq over NPINS sg13g2_io_gpio_in pins.
// Single-cycle register bus, combinational read; debounce enabled by IO_GPIO_DEBOUNCE_EN.
import sg13g2_io_gpio_pkg::*;

module sg13g2_io_gpio_bank #(
    parameter int unsigned NPINS = 8,
    parameter int unsigned DEB_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [GPIO_ADDR_W-1:0] addr,
    input  logic                   wr_en,
    input  logic [NPINS-1:0]       wdata,
    output logic [NPINS-1:0]       rdata,
    output logic [NPINS-1:0]       c2p,
    output logic [NPINS-1:0]       c2p_en,
    input  logic [NPINS-1:0]       p2c,
    output logic                   irq
);

    logic [NPINS-1:0] dout_q, dout_d;
    logic [NPINS-1:0] doe_q,  doe_d;
    logic [NPINS-1:0] ien_q,  ien_d;
    logic [NPINS-1:0] edge_q, edge_d;
    logic [NPINS-1:0] stat_q, stat_d;
    logic [NPINS-1:0] w1c;
    logic [NPINS-1:0] filt;
    logic [NPINS-1:0] evt;

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        sg13g2_io_gpio_in #(
            .DEB_W (DEB_W)
        ) u_in (
            .clk        (clk),
            .rst        (rst),
            .p2c_i      (p2c[i]),
            .ien_i      (ien_q[i]),
            .edge_sel_i (edge_q[i]),
            .filt_o     (filt[i]),
            .evt_o      (evt[i])
        );
    end

    always_comb begin
        dout_d = dout_q;
        doe_d  = doe_q;
        ien_d  = ien_q;
        edge_d = edge_q;
        w1c    = '0;
        if (wr_en) begin
            case (addr)
                GPIO_ADDR_DOUT: dout_d = wdata;
                GPIO_ADDR_DOE:  doe_d  = wdata;
                GPIO_ADDR_STAT: w1c    = wdata;
                GPIO_ADDR_IEN:  ien_d  = wdata;
                GPIO_ADDR_EDGE: edge_d = wdata;
                default: ;
            endcase
        end
        // A new event outranks a clear of the same bit in the same cycle.
        stat_d = (stat_q & ~w1c) | evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            doe_q  <= '0;
            ien_q  <= '0;
            edge_q <= '0;
            stat_q <= '0;
        end else begin
            dout_q <= dout_d;
            doe_q  <= doe_d;
            ien_q  <= ien_d;
            edge_q <= edge_d;
            stat_q <= stat_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            GPIO_ADDR_DOUT: rdata = dout_q;
            GPIO_ADDR_DOE:  rdata = doe_q;
            GPIO_ADDR_DIN:  rdata = filt;
            GPIO_ADDR_STAT: rdata = stat_q;
            GPIO_ADDR_IEN:  rdata = ien_q;
            GPIO_ADDR_EDGE: rdata = edge_q;
            default:        rdata = '0;
        endcase
    end

    assign c2p    = dout_q;
    assign c2p_en = doe_q;
    assign irq    = |stat_q;

endmodule

// File: tb/tb_sg13g2_io_gpio_bank.sv
// Directed plus random stimulus against a cycle-level behavioural model of the GPIO bank.
// Honours IO_GPIO_DEBOUNCE_EN for input latency and filtering.
module tb_sg13g2_io_gpio_bank;
    import sg13g2_io_gpio_pkg::*;

    localparam int N = 8;
`ifdef IO_GPIO_DEBOUNCE_EN
    localparam int MAXC      = 15;
    localparam int DIN_EDGES = 18;
`else
    localparam int MAXC      = 0;
    localparam int DIN_EDGES = 2;
`endif
    localparam int STAT_EDGES = DIN_EDGES + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   addr;
    logic         wr_en;
    logic [N-1:0] wdata, rdata, c2p, c2p_en, p2c;
    logic         irq;

    sg13g2_io_gpio_bank #(.NPINS(N), .DEB_W(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .wdata(wdata),
        .rdata(rdata), .c2p(c2p), .c2p_en(c2p_en), .p2c(p2c), .irq(irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: pad history, accepted input level, and register contents.
    logic [N-1:0] m_dout = '0, m_doe = '0, m_ien = '0, m_edge = '0, m_stat = '0;
    logic [N-1:0] m_d1 = '0, m_d2 = '0, m_filt = '0, m_prev = '0;
    int           m_dis[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] m_read(input logic [2:0] a);
        case (a)
            GPIO_ADDR_DOUT: return m_dout;
            GPIO_ADDR_DOE:  return m_doe;
            GPIO_ADDR_DIN:  return m_filt;
            GPIO_ADDR_STAT: return m_stat;
            GPIO_ADDR_IEN:  return m_ien;
            GPIO_ADDR_EDGE: return m_edge;
            default:        return '0;
        endcase
    endfunction

    task automatic model_edge();
        logic [N-1:0] evt, clr, old_sync;
        if (rst) begin
            {m_dout, m_doe, m_ien, m_edge, m_stat} = '0;
            {m_d1, m_d2, m_filt, m_prev} = '0;
            for (int i = 0; i < N; i++) m_dis[i] = 0;
            return;
        end
        // A pin reports when its accepted level just changed to the selected polarity.
        evt = '0;
        for (int i = 0; i < N; i++)
            if (m_ien[i] && m_filt[i] != m_prev[i] && m_filt[i] == m_edge[i]) evt[i] = 1'b1;
        clr = (wr_en && addr == GPIO_ADDR_STAT) ? wdata : '0;
        if (wr_en) begin
            if (addr == GPIO_ADDR_DOUT) m_dout = wdata;
            if (addr == GPIO_ADDR_DOE)  m_doe  = wdata;
            if (addr == GPIO_ADDR_IEN)  m_ien  = wdata;
            if (addr == GPIO_ADDR_EDGE) m_edge = wdata;
        end
        m_stat   = (m_stat & ~clr) | evt;
        m_prev   = m_filt;
        old_sync = m_d2;
        m_d2     = m_d1;
        m_d1     = p2c;
        for (int i = 0; i < N; i++) begin
            if (MAXC == 0) begin
                m_filt[i] = m_d2[i];
            end else if (old_sync[i] == m_filt[i]) begin
                m_dis[i] = 0;
            end else begin
                // Accept once the synchronised level has disagreed for MAXC+1 edges running.
                m_dis[i]++;
                if (m_dis[i] == MAXC + 1) begin
                    m_filt[i] = old_sync[i];
                    m_dis[i]  = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("c2p", c2p, m_dout);
        chk("c2p_en", c2p_en, m_doe);
        chk("irq", irq, |m_stat);
        chk("rdata", rdata, m_read(addr));
    endtask

    task automatic wr(input logic [2:0] a, input logic [N-1:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [N-1:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        rst = 1'b1; p2c = '1; addr = GPIO_ADDR_DIN; wr_en = 1'b0; wdata = '0;
        tick(); tick();
        chk("rst_c2p_en", c2p_en, 8'h00);
        chk("rst_irq", irq, 1'b0);
        rd("rst_stat", GPIO_ADDR_STAT, 8'h00);
        rst = 1'b0;
        addr = GPIO_ADDR_DIN;
        repeat (DIN_EDGES - 1) tick();
        chk("din_before", rdata, 8'h00);
        tick();
        chk("din_idle_high", rdata, 8'hFF);
        chk("no_irq_idle_high", irq, 1'b0);

        wr(GPIO_ADDR_DOUT, 8'hA5);
        wr(GPIO_ADDR_DOE, 8'h0F);
        chk("c2p_a5", c2p, 8'hA5);
        chk("c2p_en_0f", c2p_en, 8'h0F);
        rd("dout_rb", GPIO_ADDR_DOUT, 8'hA5);
        rd("doe_rb", GPIO_ADDR_DOE, 8'h0F);

        // Pin0 rising event and W1C clear.
        p2c = 8'hFE;
        repeat (STAT_EDGES + 1) tick();
        wr(GPIO_ADDR_IEN, 8'h01);
        wr(GPIO_ADDR_EDGE, 8'h01);
        addr = GPIO_ADDR_STAT;
        p2c = 8'hFF;
        repeat (STAT_EDGES - 1) tick();
        chk("stat_early", rdata, 8'h00);
        tick();
        chk("stat_set", rdata, 8'h01);
        chk("irq_set", irq, 1'b1);
        wr(GPIO_ADDR_STAT, 8'h01);
        chk("stat_w1c", rdata, 8'h00);
        chk("irq_w1c", irq, 1'b0);

        // Clear and new event on the same edge: the event wins.
        p2c = 8'hFE;
        repeat (STAT_EDGES + 1) tick();
        p2c = 8'hFF;
        repeat (STAT_EDGES - 1) tick();
        wr(GPIO_ADDR_STAT, 8'h01);
        chk("set_wins", rdata, 8'h01);
        wr(GPIO_ADDR_STAT, 8'h01);
        chk("stat_cleared", rdata, 8'h00);

        // Enabling while the level is mid-change must not set retroactively.
        wr(GPIO_ADDR_IEN, 8'h00);
        p2c = 8'hFE;
        repeat (STAT_EDGES + 1) tick();
        p2c = 8'hFF;
        repeat (DIN_EDGES) tick();
        wr(GPIO_ADDR_IEN, 8'h01);
        addr = GPIO_ADDR_STAT;
        repeat (3) tick();
        chk("no_retro", rdata, 8'h00);

        wr(GPIO_ADDR_DOE, 8'h00);
        chk("c2p_tristate", c2p, 8'hA5);
        chk("c2p_en_off", c2p_en, 8'h00);

`ifdef IO_GPIO_DEBOUNCE_EN
        wr(GPIO_ADDR_IEN, 8'h02);
        wr(GPIO_ADDR_EDGE, 8'h00);
        p2c = 8'hFD;
        repeat (10) tick();
        p2c = 8'hFF;
        repeat (20) tick();
        rd("glitch_din", GPIO_ADDR_DIN, 8'hFF);
        rd("glitch_stat", GPIO_ADDR_STAT, 8'h00);
        addr = GPIO_ADDR_DIN;
        p2c = 8'hFD;
        repeat (17) tick();
        chk("deb_k16", rdata, 8'hFF);
        tick();
        chk("deb_k17", rdata, 8'hFD);
        p2c = 8'hFF;
        repeat (9) tick();
`endif

        // Reset in the middle of an input change clears everything, no event.
        p2c = 8'hF0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd("rst_mid_din", GPIO_ADDR_DIN, 8'h00);
        rd("rst_mid_stat", GPIO_ADDR_STAT, 8'h00);
        addr = GPIO_ADDR_DIN;
        repeat (DIN_EDGES - 1) tick();
        chk("restart_before", rdata, 8'h00);
        tick();
        chk("restart_din", rdata, 8'hF0);

        // Random traffic against the model.
        wr(GPIO_ADDR_IEN, 8'hFF);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) p2c = p2c ^ (8'h01 << $urandom_range(0, 7));
            if (MAXC == 0 && $urandom_range(0, 3) == 0) p2c = p2c ^ 8'($urandom);
            wr_en = ($urandom_range(0, 3) == 0);
            addr  = 3'($urandom_range(0, 7));
            wdata = 8'($urandom);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        wr_en = 1'b0;
        rst   = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
